// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB constants, broadcast struct and wrap helper
// Purpose: default CDB widths, the broadcast record consumed by the issue
//    queue and reservation stations, and an explicit modulo-increment helper.
// Ports: none (package).
package cdb_pkg;

   localparam int CDB_TAG_W  = 6;
   localparam int CDB_DATA_W = 32;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_bcast_t;

   // Explicit wrap so non-power-of-two source counts never rely on truncation.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with rotating priority pointer
// Purpose: one-hot grant to the first requester at or after the pointer,
//    wrapping modulo NUM_SRC; pointer moves past the winner on each grant.
// Ports:
//    clk, reset  clock, synchronous active-high reset (pointer -> 0)
//    block       suppresses all grants and freezes the pointer
//    req         per-source request
//    grant       one-hot grant (0 when no request or blocked)
//    grant_idx   index of the granted source
//    grant_any   a grant was issued this cycle
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       block,
   input  logic [NUM_SRC-1:0]         req,
   output logic [NUM_SRC-1:0]         grant,
   output logic [$clog2(NUM_SRC)-1:0] grant_idx,
   output logic                       grant_any
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx_v;
   int               idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      idx_v     = '0;
      if (!reset && !block) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC)
               idx = idx - NUM_SRC;
            idx_v = IDX_W'(idx);
            if (!grant_any && req[idx_v]) begin
               grant[idx_v] = 1'b1;
               grant_idx    = idx_v;
               grant_any    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (grant_any)
         ptr <= IDX_W'(wrap_inc(int'(grant_idx), NUM_SRC));
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbitrated, registered Common Data Bus
// Purpose: picks one of NUM_SRC result producers per cycle and broadcasts its
//    tag/data one cycle later; flush squashes the current cycle's winner.
//    Optional statistics counters are enabled by macro CDB_STATS_EN.
// Ports:
//    clk, reset        clock, synchronous active-high reset
//    flush             squash: no grant this cycle, output invalid next cycle
//    src_valid/tag/data packed producer results (source i at slice i)
//    src_ready         one-hot grant back to producers
//    cdb_valid/tag/data/src  registered broadcast
//    stat_bcast, stat_conflict  saturating counters (CDB_STATS_EN only)
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
   input  logic [NUM_SRC*DATA_W-1:0]  src_data,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_data,
   output logic [$clog2(NUM_SRC)-1:0] cdb_src
`ifdef CDB_STATS_EN
   ,
   output logic [31:0]                stat_bcast,
   output logic [31:0]                stat_conflict
`endif
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic [IDX_W-1:0] win_idx;
   logic             win_any;

   // Reset and flush both block the arbiter, so src_ready is 0 and the
   // pointer holds in those cycles.
   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .block     (flush),
      .req       (src_valid),
      .grant     (src_ready),
      .grant_idx (win_idx),
      .grant_any (win_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
      end else if (win_any) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= src_tag[int'(win_idx)*TAG_W +: TAG_W];
         cdb_data  <= src_data[int'(win_idx)*DATA_W +: DATA_W];
         cdb_src   <= win_idx;
      end else begin
         // Idle or flush: payload holds, only valid drops.
         cdb_valid <= 1'b0;
      end
   end

`ifdef CDB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_bcast    <= '0;
         stat_conflict <= '0;
      end else begin
         if (cdb_valid && stat_bcast != 32'hFFFF_FFFF)
            stat_bcast <= stat_bcast + 32'd1;
         if (!flush && $countones(src_valid) > 1 && stat_conflict != 32'hFFFF_FFFF)
            stat_conflict <= stat_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with directed vectors
module tb_cdb_arbiter;

   localparam int NUM_SRC = 4;
   localparam int TAG_W   = 6;
   localparam int DATA_W  = 32;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      flush;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;
   logic [1:0]                cdb_src;
`ifdef CDB_STATS_EN
   logic [31:0]               stat_bcast;
   logic [31:0]               stat_conflict;
`endif

   cdb_arbiter #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
`ifdef CDB_STATS_EN
      ,
      .stat_bcast    (stat_bcast),
      .stat_conflict (stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        valid;
      logic        full;
      logic [5:0]  tag;
      logic [31:0] data;
      logic [1:0]  src;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [5:0]  tags  [NUM_SRC];
   logic [31:0] datas [NUM_SRC];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Monitor: compares the broadcast against the entry due this cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         check("cdb_valid", 32'(cdb_valid), 32'(e.valid));
         if (e.full) begin
            check("cdb_tag", 32'(cdb_tag), 32'(e.tag));
            check("cdb_data", cdb_data, e.data);
            check("cdb_src", 32'(cdb_src), 32'(e.src));
         end
      end
   end

   // One cycle of stimulus: drive, check the combinational grant, and queue
   // the broadcast expected after the next edge.
   task automatic step(input logic rst, input logic fl, input logic [3:0] v,
                       input logic [3:0] exp_ready, input logic exp_v,
                       input int exp_src, input logic full);
      exp_t e;
      reset     = rst;
      flush     = fl;
      src_valid = v;
      #3;
      check("src_ready", 32'(src_ready), 32'(exp_ready));
      e.due   = cyc + 1;
      e.valid = exp_v;
      e.full  = full;
      e.tag   = exp_v ? tags[exp_src]  : 6'd0;
      e.data  = exp_v ? datas[exp_src] : 32'd0;
      e.src   = exp_v ? 2'(exp_src)    : 2'd0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NUM_SRC; i++) begin
         tags[i]  = 6'(10 + i);
         datas[i] = 32'hA000_0000 + 32'(i);
      end
      tags[2]  = 6'd17;
      datas[2] = 32'hDEAD_BEEF;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_tag[i*TAG_W +: TAG_W]    = tags[i];
         src_data[i*DATA_W +: DATA_W] = datas[i];
      end
      reset     = 1'b1;
      flush     = 1'b0;
      src_valid = '0;
      @(posedge clk);
      #1;

      // Reset then idle: everything zero.
      step(1, 0, 4'b0000, 4'b0000, 0, 0, 1);
      step(1, 0, 4'b0000, 4'b0000, 0, 0, 1);
      // Single source 2, pointer moves to 3.
      step(0, 0, 4'b0100, 4'b0100, 1, 2, 1);
      // Wrap from pointer 3: source 0 then 1, pointer ends at 2.
      step(0, 0, 4'b0011, 4'b0001, 1, 0, 1);
      step(0, 0, 4'b0010, 4'b0010, 1, 1, 1);
      // Flush holds pointer at 2: next unflushed all-valid cycle grants 2.
      step(0, 1, 4'b1111, 4'b0000, 0, 0, 0);
      step(0, 0, 4'b1111, 4'b0100, 1, 2, 1);
      // Flush with only source 3 valid, then source 3 granted; pointer -> 0.
      step(0, 1, 4'b1000, 4'b0000, 0, 0, 0);
      step(0, 0, 4'b1000, 4'b1000, 1, 3, 1);
      step(0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      // All valid for 8 cycles from pointer 0.
      for (int i = 0; i < 8; i++)
         step(0, 0, 4'b1111, 4'(1 << (i % 4)), 1, i % 4, 1);
      // Reset mid-stream at the cycle source 2 would win.
      step(0, 0, 4'b1111, 4'b0001, 1, 0, 1);
      step(0, 0, 4'b1111, 4'b0010, 1, 1, 1);
      step(1, 0, 4'b1111, 4'b0000, 0, 0, 1);
      step(0, 0, 4'b1111, 4'b0001, 1, 0, 1);
      step(0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0, 0);

      @(posedge clk);
      @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
